j_mx_cell_skip_lanes: RTL and testbench

Parametrised successor of the bit-serial MX cell with input skipping, for the systolic array. A single shared weight, loaded by chained shift, is applied to a bit-serial activation stream that is distributed round-robin over LANES accumulator lanes.
Zero activations and a zero weight skip the lane. A skipped lane passes its partial sum through unchanged, and its accumulator clock-enable is held low; there is no gated clock.
Weights, data, zero flags and control are forwarded one cycle later to the next cell.

---
 rtl/j_mx_cell_skip_lanes.sv | 198 +++++++++++++++++++
 tb/tb_j_mx_cell_skip_lanes.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_mx_cell_skip_lanes.sv
// rtl/j_mx_cell_skip_lanes.sv - bit-serial MX cell with round-robin accumulator lanes and input skipping
module j_mx_cell_skip_lanes #(
  parameter int LANES                 = 4,
  parameter int DATA_WIDTH            = 2,
  parameter int W_BITS                = 8,
  parameter int A_BITS                = 8,
  parameter int ACC_W                 = 16,
  parameter int CNT_W                 = 8,
  parameter int DEFAULT_SHARED_WEIGHT = 1,
  parameter int SEL_W                 = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    dataflow_in,
  input  logic [SEL_W-1:0]         dataflow_select,
  input  logic [DATA_WIDTH-1:0]    zero_inputs_in,
  input  logic                     start_i,
  input  logic                     update_w_i,
  input  logic [LANES*ACC_W-1:0]   psum_in,
  output logic [LANES*ACC_W-1:0]   result_o,
  output logic [LANES-1:0]         result_valid_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         skip_cnt_o,
  output logic [DATA_WIDTH-1:0]    dataflow_out,
  output logic [DATA_WIDTH-1:0]    zero_inputs_out,
  output logic                     start_o,
  output logic                     update_w_o
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int K_W   = (A_BITS > 1) ? $clog2(A_BITS) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);
  localparam logic [K_W-1:0]   LAST_BIT  = K_W'(A_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // At most one lane is open at a time, and it is always the lane at ptr_q.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_next;
  logic [K_W-1:0]     k_q, k_d;
  logic [W_BITS-1:0]  shared_w;
  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-1:0]   acc_q [LANES];
  logic [LANES-1:0]   skip_q;
  logic [LANES-1:0]   ld;
  logic [LANES-1:0]   acc_en;
  logic               bit_in;
  logic               zf_in;
  logic               skip_new;
  logic               open_new;
  logic               close_cur;
  logic               running;

  assign bit_in   = dataflow_in[dataflow_select];
  assign zf_in    = zero_inputs_in[dataflow_select];
  assign skip_new = zf_in | (shared_w == '0);
  assign w_ext    = ACC_W'(shared_w);
  assign ptr_next = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
  assign running  = (state_q == ST_OPEN) & ~update_w_i & ~start_i;
  assign busy_o   = (state_q == ST_OPEN);

  // Lane state, lane pointer and bit index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= LAST_LANE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
    end
  end

  // Open/close decisions; a weight update overrides a start in the same cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    k_d       = k_q;
    open_new  = 1'b0;
    close_cur = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (update_w_i) begin
          ptr_d = LAST_LANE;
        end else if (start_i) begin
          open_new = 1'b1;
          state_d  = ST_OPEN;
          ptr_d    = ptr_next;
          k_d      = K_W'(1);
        end
      end
      ST_OPEN: begin
        if (update_w_i) begin
          close_cur = 1'b1;
          state_d   = ST_IDLE;
          ptr_d     = LAST_LANE;
          k_d       = '0;
        end else if (start_i) begin
          close_cur = 1'b1;
          open_new  = 1'b1;
          ptr_d     = ptr_next;
          k_d       = K_W'(1);
        end else if (k_q == LAST_BIT) begin
          close_cur = 1'b1;
          state_d   = ST_IDLE;
          k_d       = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-lane load strobe (psum capture) and accumulate enable; skipped lanes never enable.
  always_comb begin
    ld     = '0;
    acc_en = '0;
    for (int l = 0; l < LANES; l++) begin
      ld[l]     = open_new & (ptr_next == PTR_W'(l));
      acc_en[l] = (ld[l] & ~skip_new) |
                  (running & (ptr_q == PTR_W'(l)) & ~skip_q[l]);
    end
  end

  // Accumulators: load psum plus bit 0 on open, then add shifted weight per set bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (ld[l]) begin
          acc_q[l] <= psum_in[l*ACC_W +: ACC_W] + ((bit_in & ~skip_new) ? w_ext : '0);
        end else if (acc_en[l]) begin
          acc_q[l] <= acc_q[l] + (bit_in ? (w_ext << k_q) : '0);
        end
      end
    end
  end

  // Skip flag is captured when a lane opens and held for the whole operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_q <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (ld[l]) skip_q[l] <= skip_new;
      end
    end
  end

  // One-cycle valid pulse for the lane that closed, plus the saturating skip counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_valid_o <= '0;
      skip_cnt_o     <= '0;
    end else begin
      result_valid_o <= close_cur ? (LANES'(1) << ptr_q) : '0;
      if (open_new && skip_new && (skip_cnt_o != CNT_MAX)) begin
        skip_cnt_o <= skip_cnt_o + 1'b1;
      end
    end
  end

  // Shared weight shifts in from the top; the displaced low chunk goes downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shared_w <= W_BITS'(DEFAULT_SHARED_WEIGHT);
    end else if (update_w_i) begin
      shared_w <= {dataflow_in, shared_w[W_BITS-1:DATA_WIDTH]};
    end
  end

  // One-cycle forwarding to the next cell; during a weight load only the weight chain moves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataflow_out    <= '0;
      zero_inputs_out <= '0;
      start_o         <= 1'b0;
      update_w_o      <= 1'b0;
    end else begin
      dataflow_out    <= update_w_i ? shared_w[DATA_WIDTH-1:0] : dataflow_in;
      zero_inputs_out <= update_w_i ? '0 : zero_inputs_in;
      start_o         <= start_i & ~update_w_i;
      update_w_o      <= update_w_i;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_result
    assign result_o[g*ACC_W +: ACC_W] = acc_q[g];
  end

endmodule

// File: tb/tb_j_mx_cell_skip_lanes.sv
// tb/tb_j_mx_cell_skip_lanes.sv - self-checking bench for j_mx_cell_skip_lanes
module tb_j_mx_cell_skip_lanes;

  localparam int LANES = 4;
  localparam int DW    = 2;
  localparam int WB    = 8;
  localparam int AB    = 4;
  localparam int AW    = 16;
  localparam int CW    = 8;
  localparam int DEF   = 1;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [DW-1:0]         dataflow_in = '0;
  logic [0:0]            dataflow_select = '0;
  logic [DW-1:0]         zero_inputs_in = '0;
  logic                  start_i = 1'b0;
  logic                  update_w_i = 1'b0;
  logic [LANES*AW-1:0]   psum_in = '0;
  logic [LANES*AW-1:0]   result_o;
  logic [LANES-1:0]      result_valid_o;
  logic                  busy_o;
  logic [CW-1:0]         skip_cnt_o;
  logic [DW-1:0]         dataflow_out;
  logic [DW-1:0]         zero_inputs_out;
  logic                  start_o;
  logic                  update_w_o;

  j_mx_cell_skip_lanes #(
    .LANES(LANES), .DATA_WIDTH(DW), .W_BITS(WB), .A_BITS(AB),
    .ACC_W(AW), .CNT_W(CW), .DEFAULT_SHARED_WEIGHT(DEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dataflow_in(dataflow_in),
    .dataflow_select(dataflow_select), .zero_inputs_in(zero_inputs_in),
    .start_i(start_i), .update_w_i(update_w_i), .psum_in(psum_in),
    .result_o(result_o), .result_valid_o(result_valid_o), .busy_o(busy_o),
    .skip_cnt_o(skip_cnt_o), .dataflow_out(dataflow_out),
    .zero_inputs_out(zero_inputs_out), .start_o(start_o), .update_w_o(update_w_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each open operation is tracked as (psum, weight, skip, activation value so far).
  int          m_w, m_ptr, m_lane, m_k, m_val, m_wop, m_psum, m_cnt;
  bit          m_open, m_skip;
  int          m_res [LANES];
  logic [LANES-1:0] m_valid;
  logic [DW-1:0]    m_df, m_zf;
  bit          m_st, m_up;

  task automatic mreset();
    m_w = DEF; m_ptr = LANES - 1; m_lane = 0; m_k = 0; m_val = 0; m_wop = 0;
    m_psum = 0; m_cnt = 0; m_open = 0; m_skip = 0;
    for (int l = 0; l < LANES; l++) m_res[l] = 0;
    m_valid = '0; m_df = '0; m_zf = '0; m_st = 0; m_up = 0;
  endtask

  function automatic int lane_value();
    return (m_psum + (m_skip ? 0 : m_wop * m_val)) % (1 << AW);
  endfunction

  task automatic mstep();
    int b, z, oldw;
    b = int'(dataflow_in[dataflow_select]);
    z = int'(zero_inputs_in[dataflow_select]);
    oldw = m_w;
    m_valid = '0;
    if (update_w_i) begin
      if (m_open) begin m_valid[m_lane] = 1'b1; m_open = 0; end
      m_ptr = LANES - 1;
      m_w = (m_w >> DW) | (int'(dataflow_in) << (WB - DW));
    end else if (start_i) begin
      if (m_open) m_valid[m_lane] = 1'b1;
      m_ptr  = (m_ptr + 1) % LANES;
      m_lane = m_ptr;
      m_open = 1; m_k = 0; m_val = b; m_wop = m_w;
      m_skip = (z != 0) || (m_w == 0);
      if (m_skip && m_cnt < (1 << CW) - 1) m_cnt++;
      m_psum = int'(psum_in[m_lane*AW +: AW]);
      m_res[m_lane] = lane_value();
    end else if (m_open) begin
      m_k++;
      m_val += b << m_k;
      m_res[m_lane] = lane_value();
      if (m_k == AB - 1) begin m_valid[m_lane] = 1'b1; m_open = 0; end
    end
    m_df = update_w_i ? DW'(oldw) : dataflow_in;
    m_zf = update_w_i ? '0 : zero_inputs_in;
    m_st = start_i && !update_w_i;
    m_up = update_w_i;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mreset();
    else mstep();
  end

  // Every-cycle comparison of all outputs against the model.
  bit cmp_on = 0;
  always @(negedge clk) begin
    logic [LANES*AW-1:0] er;
    if (cmp_on) begin
      for (int l = 0; l < LANES; l++) er[l*AW +: AW] = AW'(m_res[l]);
      chk("result_o", result_o, er);
      chk("result_valid_o", result_valid_o, m_valid);
      chk("busy_o", busy_o, m_open);
      chk("skip_cnt_o", skip_cnt_o, m_cnt);
      chk("dataflow_out", dataflow_out, m_df);
      chk("zero_inputs_out", zero_inputs_out, m_zf);
      chk("start_o", start_o, m_st);
      chk("update_w_o", update_w_o, m_up);
    end
  end

  // Observers for accumulator enable and per-lane valid pulse counts.
  int watch_lane = -1;
  bit en_seen = 0;
  always @(posedge clk) if (watch_lane >= 0 && dut.acc_en[watch_lane]) en_seen = 1;

  bit cnt_on = 0;
  int pulses [LANES];
  always @(negedge clk) if (cnt_on) for (int l = 0; l < LANES; l++) if (result_valid_o[l]) pulses[l]++;

  task automatic cyc(input logic [DW-1:0] din, input logic [DW-1:0] zin, input logic st, input logic up);
    @(negedge clk);
    dataflow_in = din; zero_inputs_in = zin; start_i = st; update_w_i = up;
  endtask

  task automatic load_w(input logic [7:0] w);
    for (int i = 0; i < WB / DW; i++) cyc(DW'(w >> (i * DW)), '0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] chunks [4];
    logic [1:0] disp   [4];
    int         bits4  [12];
    mreset();
    psum_in = {16'd300, 16'd200, 16'd77, 16'd5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_on = 1;
    chk("rst_result", result_o, 64'h0);
    chk("rst_busy", busy_o, 0);
    chk("rst_skip_cnt", skip_cnt_o, 0);
    chk("rst_shared_w", dut.shared_w, DEF);

    // Weight load: 01,10,11,00 -> 0x39, displaced chunks 01,00,00,00
    chunks = '{2'b01, 2'b10, 2'b11, 2'b00};
    disp   = '{2'b01, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      cyc(chunks[i], 2'b00, 1'b0, 1'b1);
      if (i > 0) chk("t1_disp", dataflow_out, disp[i-1]);
    end
    cyc(0, 0, 0, 0);
    chk("t1_disp", dataflow_out, disp[3]);
    chk("t1_shared_w", dut.shared_w, 8'h39);

    // shared_W = 3, bits 1,0,1,1 on lane 0 with psum 5 -> 44
    load_w(8'h03);
    watch_lane = 0; en_seen = 0;
    cyc(2'b01, 0, 1, 0);
    cyc(2'b00, 0, 0, 0);
    cyc(2'b01, 0, 0, 0);
    cyc(2'b01, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t2_result", result_o[0 +: AW], 44);
    chk("t2_valid", result_valid_o, 4'b0001);
    chk("t2_en_active", en_seen, 1);
    cyc(0, 0, 0, 0);
    chk("t2_valid_off", result_valid_o, 4'b0000);
    chk("t2_busy_off", busy_o, 0);

    // Zero-flag skip on lane 1, psum 77
    watch_lane = 1; en_seen = 0;
    cyc(2'b01, 2'b01, 1, 0);
    repeat (3) cyc(2'b01, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_result", result_o[AW +: AW], 77);
    chk("t3_valid", result_valid_o, 4'b0010);
    chk("t3_skip_cnt", skip_cnt_o, 1);
    chk("t3_en_low", en_seen, 0);

    // Zero-weight skip (update resets the pointer, so lane 0)
    load_w(8'h00);
    watch_lane = 0; en_seen = 0;
    cyc(2'b01, 0, 1, 0);
    repeat (3) cyc(2'b01, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3b_result", result_o[0 +: AW], 5);
    chk("t3b_skip_cnt", skip_cnt_o, 2);
    chk("t3b_en_low", en_seen, 0);
    watch_lane = -1;

    // Five starts two cycles apart, W=5, bit taken from flow 1
    load_w(8'h05);
    dataflow_select = 1'b1;
    bits4 = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    for (int l = 0; l < LANES; l++) pulses[l] = 0;
    cnt_on = 1;
    for (int i = 0; i < 12; i++) begin
      logic b;
      b = bits4[i][0];
      cyc({b, ~b}, 2'b01, ((i % 2) == 0) && (i <= 8), 0);
    end
    repeat (2) cyc(0, 0, 0, 0);
    cnt_on = 0;
    chk("t4_pulses_l0", pulses[0], 2);
    chk("t4_pulses_l1", pulses[1], 1);
    chk("t4_pulses_l2", pulses[2], 1);
    chk("t4_pulses_l3", pulses[3], 1);
    chk("t4_l0", result_o[0 +: AW], 80);
    chk("t4_l1", result_o[AW +: AW], 92);
    chk("t4_l2", result_o[2*AW +: AW], 210);
    chk("t4_l3", result_o[3*AW +: AW], 315);
    dataflow_select = 1'b0;

    // Weight update at k=2 of lane 2
    cyc(2'b01, 0, 1, 0);
    cyc(2'b01, 0, 0, 0);
    cyc(2'b01, 0, 1, 0);
    cyc(2'b01, 0, 0, 0);
    chunks = '{2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      cyc(chunks[i], 2'b11, 1, 1);
      if (i == 1) begin
        chk("t5_valid", result_valid_o, 4'b0100);
        chk("t5_partial", result_o[2*AW +: AW], 215);
      end
      if (i > 0) begin
        chk("t5_start_o", start_o, 0);
        chk("t5_zf_out", zero_inputs_out, 0);
        chk("t5_upd_o", update_w_o, 1);
      end
    end
    cyc(2'b01, 0, 1, 0);
    chk("t5_start_o_last", start_o, 0);
    chk("t5_zf_out_last", zero_inputs_out, 0);
    cyc(2'b00, 0, 0, 0);
    chk("t5_busy", busy_o, 1);
    chk("t5_lane0", result_o[0 +: AW], 10);

    // Asynchronous reset at k=3
    cyc(2'b01, 0, 0, 0);
    cyc(2'b01, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_result", result_o, 64'h0);
    chk("t6_valid", result_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_skip_cnt", skip_cnt_o, 0);
    chk("t6_df_out", dataflow_out, 0);
    chk("t6_upd_o", update_w_o, 0);
    chk("t6_shared_w", dut.shared_w, DEF);
    @(negedge clk);
    reset_n = 1'b1;
    dataflow_in = '0; start_i = 0; update_w_i = 0; zero_inputs_in = '0;
    cyc(2'b01, 0, 1, 0);
    chk("t6_no_pulse", result_valid_o, 0);
    cyc(2'b01, 0, 0, 0);
    cyc(2'b00, 0, 0, 0);
    cyc(2'b01, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_result_after", result_o[0 +: AW], 16);
    chk("t6_valid_after", result_valid_o, 4'b0001);
    repeat (2) cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
